mul8_shift_add: RTL

Sequential 8x8 unsigned shift-and-add multiplier: the control and datapath stage that produces the two 16-bit operands for the team's 16-bit ripple adder (`adder32`) each cycle and accumulates its sum. It accepts one operand pair per start handshake, runs a fixed 8 iterations, and presents a registered 16-bit product with a one-cycle done pulse. It sits between the operand source (register file or test driver) and any product consumer in the mul_8_8 design.

---
 rtl/mul8_pkg.sv | 15 +
 rtl/mul8_shift_add_adder32.sv | 22 ++
 rtl/mul8_shift_add.sv | 86 ++++++++
 3 files changed

// File: rtl/mul8_pkg.sv
// Shared types and constants for the sequential 8x8 shift-and-add multiplier.
package mul8_pkg;

    localparam int WIDTH  = 8;
    localparam int PWIDTH = 16;
    localparam int CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_ITER = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul8_shift_add_adder32.sv
// 16-bit ripple-carry adder with carry-in tied low; built bit-by-bit so the
// carry chain is explicit. The final carry-out is never needed by the multiplier.
module adder32 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W-1:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        if (i < W - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/mul8_shift_add.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one accept, 8 accumulate
// edges, one DONE cycle with a registered 16-bit product.
module mul8_shift_add
    import mul8_pkg::*;
#(
    parameter int WIDTH = mul8_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;

    state_t           state, state_nxt;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_nxt;
    logic [PW-1:0]    sum;
    logic [CNT_W-1:0] cnt;

    adder32 #(.W(PW)) u_adder (
        .a   (acc),
        .b   (mcand),
        .sum (sum)
    );

    assign acc_nxt = mplier[0] ? sum : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST_ITER) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{(PW-WIDTH){1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Capture the final sum on the same edge it lands in acc.
                    if (cnt == LAST_ITER) product <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN) || (state == DONE);
    assign done  = (state == DONE);

endmodule
